puf_challenge_sequencer: RTL and testbench
==========================================

Name: puf_challenge_sequencer

Overview:
- Drives the challenge bits that form the select lines (S0..S3 groups) of the arbiter-PUF mux chain, one challenge at a time.
- For each challenge it launches the race and samples the arbiter output, collecting RESP_W response bits per request.
- Challenges are generated by an on-chip 64-bit LFSR seeded by the requester.
- Sits between the host/UART command logic and the PUF delay chain.

Parameters:
- CHAL_W, 64: challenge width; must be ≤ 64. CHALLENGE = low CHAL_W bits of the LFSR.
- RESP_W, 16: response bits collected per request; range 1..64.
- SETTLE_CYC, 8: cycles to wait after a challenge change, and again after launch; must be ≥ 1.

Ports:
- CLK, in, 1: system clock, rising edge.
- RST_N, in, 1: asynchronous active-low reset.
- START, in, 1: request pulse; accepted only in IDLE.
- SEED, in, 64: LFSR seed, sampled with an accepted START.
- ABORT, in, 1: synchronous abort of a running request.
- ARB_OUT, in, 1: arbiter latch output; already registered, sampled directly.
- CHALLENGE, out, CHAL_W: mux select bits to the PUF chain.
- LAUNCH, out, 1: one-cycle race launch pulse.
- BUSY, out, 1: high in every state except IDLE.
- RESPONSE, out, RESP_W: collected response; the first bit ends up in the MSB.
- RESP_VALID, out, 1: RESPONSE valid; held until RESP_ACK.
- RESP_ACK, in, 1: consumer acknowledge.

Behaviour:
- Reset values: async RST_N low forces all outputs and state to 0.
  - CHALLENGE=0, LAUNCH=0, BUSY=0, RESPONSE=0, RESP_VALID=0; state=IDLE.
  - Reset may occur mid-operation; no partial result survives it.
- States: IDLE, SETUP, FIRE, WAIT, CAPTURE, DONE.
- IDLE:
  - START=1 loads LFSR with SEED (SEED==0 is replaced by 64'h1).
  - CHALLENGE <= LFSR[CHAL_W-1:0], bit index = 0, RESPONSE cleared.
  - Next state SETUP.
- SETUP: hold CHALLENGE for SETTLE_CYC cycles, then FIRE.
- FIRE: LAUNCH=1 for exactly this one cycle, then WAIT.
- WAIT: SETTLE_CYC cycles, then CAPTURE.
- CAPTURE:
  - RESPONSE <= {RESPONSE[RESP_W-2:0], ARB_OUT}; index++.
  - If index == RESP_W, go to DONE.
  - Otherwise step the LFSR once, drive the new value on CHALLENGE, go to SETUP.
- LFSR: Fibonacci, polynomial x^64+x^63+x^61+x^60+1.
  - Shift left; new LSB = b63^b62^b60^b59.
- Per-bit time: 2*SETTLE_CYC+2 cycles.
- START to RESP_VALID: 1 + RESP_W*(2*SETTLE_CYC+2) cycles. Defaults give 289.
- DONE:
  - RESP_VALID=1, BUSY=1; RESPONSE and CHALLENGE stable.
  - RESP_ACK=1 clears RESP_VALID and returns to IDLE next cycle.
- ABORT=1 in any non-IDLE state:
  - Next state IDLE; LAUNCH=0, RESP_VALID=0.
  - RESPONSE is retained but is not valid.
  - ABORT has priority over RESP_ACK.
- Ignored inputs:
  - START outside IDLE is ignored, including in the same cycle as RESP_ACK in DONE.
  - RESP_ACK outside DONE is ignored.
  - ABORT in IDLE is ignored.
- CHALLENGE changes only on entering SETUP; it never changes in FIRE, WAIT or CAPTURE.

Optional Feature:
- Macro: PUF_MAJORITY_VOTE_EN.
- When defined:
  - Each challenge is evaluated 3 times as FIRE→WAIT→CAPTURE, with CHALLENGE unchanged and no SETUP between evaluations.
  - The stored bit is the majority of the 3 ARB_OUT samples.
  - Per-bit time: SETTLE_CYC + 3*(SETTLE_CYC+2) cycles. Defaults give 38 per bit and 1+16*38 = 609 total.
  - A 2-bit eval counter and a 2-bit ones counter are added; they are reset by RST_N and by ABORT.
- When undefined: single evaluation, timing exactly as in Behaviour.

Test Plan:
- Nominal response: SETTLE_CYC=2, RESP_W=4, SEED=64'h5, ARB_OUT tied 1, START pulse → 4 LAUNCH pulses spaced 6 cycles apart; RESP_VALID at cycle 25 after START; RESPONSE=4'hF.
- Zero seed and LFSR sequence: SEED=0 → first CHALLENGE=64'h1, then 64'h2, 64'h4, 64'h8.
- Bit ordering: ARB_OUT driven 1,0,1,1 on successive CAPTURE cycles → RESPONSE=4'hB.
- Handshake hold: RESP_ACK held 0 for 10 cycles after DONE → RESP_VALID and RESPONSE stable throughout.
  - Then RESP_ACK and START high in the same cycle → IDLE next cycle; START ignored; BUSY=0.
- Abort and reset:
  - ABORT during the 2nd WAIT → IDLE next cycle; RESP_VALID never asserts.
  - RST_N low during FIRE → all outputs 0 immediately (asynchronous).
- Majority vote (PUF_MAJORITY_VOTE_EN defined): ARB_OUT pattern 1,0,1 per challenge → every bit 1; RESP_VALID at cycle 1+4*14=57.

Source files
------------

// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF challenge sequencer: LFSR-generated challenges, timed launch/capture, response collection.
// Optional build macro PUF_MAJORITY_VOTE_EN: three evaluations per challenge, majority-voted bit.
module puf_challenge_sequencer #(
    parameter int CHAL_W     = 64,
    parameter int RESP_W     = 16,
    parameter int SETTLE_CYC = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [63:0]       seed,
    input  logic              abort,
    input  logic              arb_out,
    output logic [CHAL_W-1:0] challenge,
    output logic              launch,
    output logic              busy,
    output logic [RESP_W-1:0] response,
    output logic              resp_valid,
    input  logic              resp_ack
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_FIRE    = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int               CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam int               IDX_W    = 7;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RESP_W - 1);

    if (CHAL_W < 1 || CHAL_W > 64) begin : g_bad_chal_w
        $error("CHAL_W must be in 1..64");
    end
    if (RESP_W < 1 || RESP_W > 64) begin : g_bad_resp_w
        $error("RESP_W must be in 1..64");
    end
    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("SETTLE_CYC must be at least 1");
    end

    // Fibonacci LFSR, x^64+x^63+x^61+x^60+1, shifting toward the MSB.
    function automatic logic [63:0] lfsr_step(input logic [63:0] s);
        return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    function automatic logic [63:0] seed_fix(input logic [63:0] s);
        return (s == 64'd0) ? 64'd1 : s;
    endfunction

    function automatic logic [RESP_W-1:0] shift_in(input logic [RESP_W-1:0] r, input logic b);
        return (r << 1) | RESP_W'(b);
    endfunction

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [63:0]      lfsr;
    logic [63:0]      seed_eff;
    logic [63:0]      lfsr_nxt;
    logic             bit_done;
    logic             cap_bit;
    logic             abort_run;

    assign seed_eff  = seed_fix(seed);
    assign lfsr_nxt  = lfsr_step(lfsr);
    assign abort_run = abort && (state != S_IDLE);

    assign busy       = (state != S_IDLE);
    assign launch     = (state == S_FIRE);
    assign resp_valid = (state == S_DONE);

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0] eval_cnt;
    logic [1:0] ones_cnt;
    logic [1:0] ones_nxt;

    // Two ones out of three evaluations decide the bit; ones_nxt never exceeds 3.
    assign ones_nxt = ones_cnt + {1'b0, arb_out};
    assign bit_done = (eval_cnt == 2'd2);
    assign cap_bit  = ones_nxt[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eval_cnt <= 2'd0;
            ones_cnt <= 2'd0;
        end else if (abort_run) begin
            eval_cnt <= 2'd0;
            ones_cnt <= 2'd0;
        end else if (state == S_CAPTURE) begin
            if (bit_done) begin
                eval_cnt <= 2'd0;
                ones_cnt <= 2'd0;
            end else begin
                eval_cnt <= eval_cnt + 2'd1;
                ones_cnt <= ones_nxt;
            end
        end
    end
`else
    assign bit_done = 1'b1;
    assign cap_bit  = arb_out;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            idx       <= '0;
            lfsr      <= '0;
            challenge <= '0;
            response  <= '0;
        end else if (abort_run) begin
            // The partial response is kept for inspection but never flagged valid.
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lfsr      <= seed_eff;
                        challenge <= seed_eff[CHAL_W-1:0];
                        idx       <= '0;
                        cnt       <= '0;
                        response  <= '0;
                        state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_FIRE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_FIRE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_CAPTURE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    if (!bit_done) begin
                        state <= S_FIRE;
                    end else begin
                        response <= shift_in(response, cap_bit);
                        idx      <= idx + IDX_W'(1);
                        if (idx == IDX_LAST) begin
                            state <= S_DONE;
                        end else begin
                            // The challenge only moves here, on the way back into SETUP.
                            lfsr      <= lfsr_nxt;
                            challenge <= lfsr_nxt[CHAL_W-1:0];
                            cnt       <= '0;
                            state     <= S_SETUP;
                        end
                    end
                end
                S_DONE: begin
                    if (resp_ack) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Self-checking bench for puf_challenge_sequencer: vector table, corner sequences, randomized runs.
module tb_puf_challenge_sequencer;

    localparam int CHAL_W     = 64;
    localparam int RESP_W     = 4;
    localparam int SETTLE_CYC = 2;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int EVALS   = 3;
    localparam int PER_BIT = SETTLE_CYC + 3 * (SETTLE_CYC + 2);
`else
    localparam int EVALS   = 1;
    localparam int PER_BIT = 2 * SETTLE_CYC + 2;
`endif
    localparam int LAT = 1 + RESP_W * PER_BIT;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [63:0]       seed;
    logic              abort;
    logic              arb_out;
    logic [CHAL_W-1:0] challenge;
    logic              launch;
    logic              busy;
    logic [RESP_W-1:0] response;
    logic              resp_valid;
    logic              resp_ack;

    int errors = 0;
    int checks = 0;
    logic [63:0] lchal [$];

    puf_challenge_sequencer #(
        .CHAL_W(CHAL_W), .RESP_W(RESP_W), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .abort(abort),
        .arb_out(arb_out), .challenge(challenge), .launch(launch), .busy(busy),
        .response(response), .resp_valid(resp_valid), .resp_ack(resp_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [63:0]       sd;
        logic [RESP_W-1:0] bits;      // bit b = value captured for the b-th challenge
        logic [RESP_W-1:0] exp_resp;
        logic [63:0]       exp_chal0;
    } vec_t;

    vec_t tbl [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Reference model: the LFSR rule as a tap mask (bits 63,62,60,59) and parity.
    function automatic logic [63:0] ref_step(input logic [63:0] s);
        return (s << 1) | {63'd0, ^(s & 64'hD800_0000_0000_0000)};
    endfunction

    function automatic logic [63:0] ref_chal(input logic [63:0] sd, input int k);
        logic [63:0] s;
        s = (sd == 64'd0) ? 64'd1 : sd;
        for (int i = 0; i < k; i++) s = ref_step(s);
        return s;
    endfunction

    // Response from per-launch arbiter samples: majority over EVALS samples, first bit in MSB.
    function automatic logic [RESP_W-1:0] ref_resp(input logic [63:0] arb);
        logic [RESP_W-1:0] r;
        r = '0;
        for (int b = 0; b < RESP_W; b++) begin
            int ones;
            ones = 0;
            for (int e = 0; e < EVALS; e++) ones += int'(arb[b*EVALS+e]);
            r[RESP_W-1-b] = (2 * ones > EVALS);
        end
        return r;
    endfunction

    // Per-launch samples whose vote equals bits[b]: b, ~b, b for three evaluations.
    function automatic logic [63:0] spread(input logic [RESP_W-1:0] bits);
        logic [63:0] v;
        v = '0;
        for (int b = 0; b < RESP_W; b++)
            for (int e = 0; e < EVALS; e++)
                v[b*EVALS+e] = (e == 1) ? ~bits[b] : bits[b];
        return v;
    endfunction

    function automatic int exp_gap(input int k);
        return (k % EVALS != 0) ? SETTLE_CYC + 2 : 2 * SETTLE_CYC + 2;
    endfunction

    task automatic run_req(input logic [63:0] sd, input logic [63:0] arb, input bit ack_noise,
                           output int lat, output int nl, output int first_l,
                           output int bad_gap, output int nchg, output logic [63:0] ch0);
        int last_l;
        logic [63:0] prev;
        lat = -1; nl = 0; first_l = -1; bad_gap = 0; nchg = 0; last_l = 0;
        lchal.delete();
        seed  = sd;
        start = 1'b1;
        tick();
        start = 1'b0;
        ch0   = challenge;
        prev  = challenge;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            resp_ack = ack_noise && (cyc == 2);
            if (challenge !== prev) nchg++;
            prev = challenge;
            if (launch) begin
                if (nl == 0) first_l = cyc;
                else if (cyc - last_l != exp_gap(nl)) bad_gap++;
                last_l = cyc;
                lchal.push_back(challenge);
                nl++;
                if (nl <= 64) arb_out = arb[nl-1];
            end
            if (resp_valid) begin
                lat = cyc;
                break;
            end
            tick();
        end
        resp_ack = 1'b0;
    endtask

    task automatic check_run(input string tag, input logic [63:0] sd, input logic [63:0] arb,
                             input bit ack_noise);
        int lat, nl, first_l, bad_gap, nchg, mism;
        logic [63:0] ch0;
        run_req(sd, arb, ack_noise, lat, nl, first_l, bad_gap, nchg, ch0);
        chk({tag, "_latency"}, 64'(lat), 64'(LAT));
        chk({tag, "_launches"}, 64'(nl), 64'(RESP_W * EVALS));
        chk({tag, "_first_launch"}, 64'(first_l), 64'(SETTLE_CYC + 1));
        chk({tag, "_launch_gaps_bad"}, 64'(bad_gap), 64'd0);
        chk({tag, "_chal_changes"}, 64'(nchg), 64'(RESP_W - 1));
        chk({tag, "_chal0"}, ch0, ref_chal(sd, 0));
        mism = 0;
        foreach (lchal[k]) if (lchal[k] !== ref_chal(sd, k / EVALS)) mism++;
        chk({tag, "_chal_seq_bad"}, 64'(mism), 64'd0);
        chk({tag, "_response"}, 64'(response), 64'(ref_resp(arb)));
    endtask

    task automatic ack_done(input string tag);
        resp_ack = 1'b1;
        tick();
        resp_ack = 1'b0;
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        chk({tag, "_idle_valid"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        int lat, nl, first_l, bad_gap, nchg, bad, cnt;
        logic [63:0] ch0;
        logic [RESP_W-1:0] saved;
        bit found;

        tbl[0] = '{64'h5,                   4'b1111, 4'hF, 64'h5};
        tbl[1] = '{64'h0,                   4'b1101, 4'hB, 64'h1};
        tbl[2] = '{64'hFFFF_0000_1234_5678, 4'b0000, 4'h0, 64'hFFFF_0000_1234_5678};
        tbl[3] = '{64'h8000_0000_0000_0000, 4'b0110, 4'h6, 64'h8000_0000_0000_0000};

        rst_n = 1'b0; start = 1'b0; seed = '0; abort = 1'b0; arb_out = 1'b0; resp_ack = 1'b0;
        tick();
        tick();
        chk("rst_challenge", challenge, 64'd0);
        chk("rst_launch", 64'(launch), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_response", 64'(response), 64'd0);
        chk("rst_valid", 64'(resp_valid), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            check_run(tag, tbl[i].sd, spread(tbl[i].bits), 1'b0);
            chk({tag, "_table_resp"}, 64'(response), 64'(tbl[i].exp_resp));
            chk({tag, "_table_chal0"}, lchal.size() > 0 ? lchal[0] : 64'hX, tbl[i].exp_chal0);
            if (tbl[i].sd == 64'd0) begin
                for (int k = 0; k < RESP_W; k++)
                    chk($sformatf("zero_seed_chal%0d", k),
                        (lchal.size() > k * EVALS) ? lchal[k*EVALS] : 64'hX, 64'd1 << k);
            end
            ack_done(tag);
        end

        // Handshake: result held while unacknowledged, then ack+start together returns to IDLE.
        run_req(64'h5, spread(4'b1011), 1'b0, lat, nl, first_l, bad_gap, nchg, ch0);
        chk("hold_latency", 64'(lat), 64'(LAT));
        saved = response;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (resp_valid !== 1'b1 || response !== saved || launch !== 1'b0) bad++;
        end
        chk("hold_unstable_cycles", 64'(bad), 64'd0);
        chk("hold_response", 64'(response), 64'(ref_resp(spread(4'b1011))));
        resp_ack = 1'b1;
        start    = 1'b1;
        tick();
        resp_ack = 1'b0;
        start    = 1'b0;
        chk("ack_start_busy", 64'(busy), 64'd0);
        chk("ack_start_valid", 64'(resp_valid), 64'd0);
        tick();
        chk("ack_start_ignored_busy", 64'(busy), 64'd0);

        // Abort in the second WAIT.
        arb_out = 1'b1;
        seed    = 64'h5;
        start   = 1'b1;
        tick();
        start = 1'b0;
        nl = 0;
        for (int c = 0; c < 200 && nl < 2; c++) begin
            if (launch) nl++;
            if (nl < 2) tick();
        end
        chk("abort_second_launch_seen", 64'(nl), 64'd2);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_launch", 64'(launch), 64'd0);
        chk("abort_valid", 64'(resp_valid), 64'd0);
        chk("abort_response_kept", 64'(response), (EVALS == 1) ? 64'd1 : 64'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (resp_valid || busy) cnt++;
        end
        chk("abort_stays_idle", 64'(cnt), 64'd0);

        // Asynchronous reset during FIRE.
        seed  = 64'h1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (launch) found = 1'b1;
            else tick();
        end
        chk("rst_fire_launch_seen", 64'(found), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_fire_challenge", challenge, 64'd0);
        chk("rst_fire_launch", 64'(launch), 64'd0);
        chk("rst_fire_busy", 64'(busy), 64'd0);
        chk("rst_fire_response", 64'(response), 64'd0);
        chk("rst_fire_valid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Randomized seeds and per-launch arbiter samples, with a stray ack while busy.
        for (int r = 0; r < 6; r++) begin
            logic [63:0] sd, arb;
            string tag;
            tag = $sformatf("rand%0d", r);
            sd  = (r == 0) ? 64'd0 : {$urandom, $urandom};
            arb = {$urandom, $urandom};
            check_run(tag, sd, arb, 1'b1);
            ack_done(tag);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
